// File: rtl/mixer_tune_pkg.sv
// mixer_tune_pkg: state codes, step table and default tuning limits for mixer_tune_ctrl
package mixer_tune_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_DWELL  = 3'd2,
    S_STEP   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;
  localparam int unsigned DEF_F_MIN = 13422;
  localparam int unsigned DEF_F_MAX = 40265318;
  // phase increments for 1/5/10/100 kHz at a 50 MHz clock
  function automatic logic [31:0] step_val(input logic [1:0] sel);
    return sel == 2'd0 ? 32'd1342 : sel == 2'd1 ? 32'd6711 : sel == 2'd2 ? 32'd13422 : 32'd134218;
  endfunction
endpackage

// File: rtl/mixer_tune_settle.sv
// mixer_tune_settle: loadable down-counter; mute while nonzero, done on its last muted cycle
module mixer_tune_settle #(
  parameter int CYCLES = 64
) (
  input  logic CLK,
  input  logic RSTb,
  input  logic load,
  output logic mute,
  output logic done
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge CLK or negedge RSTb)
    if (!RSTb) cnt <= '0;
    else cnt <= load ? W'(CYCLES) : cnt - W'(mute);
  assign mute = cnt != '0;
  assign done = cnt == W'(1);
endmodule

// File: rtl/mixer_tune_ctrl.sv
// mixer_tune_ctrl: NCO phase-increment arbiter (host > buttons > scanner) with post-retune mute.
// The band scanner (DWELL/STEP/HOLD) is only built when MIXER_TUNE_SCAN_EN is defined.
module mixer_tune_ctrl
  import mixer_tune_pkg::*;
#(
  parameter int PHASE_BITS = 26,
  parameter logic [PHASE_BITS-1:0] F_MIN = PHASE_BITS'(DEF_F_MIN),
  parameter logic [PHASE_BITS-1:0] F_MAX = PHASE_BITS'(DEF_F_MAX),
  parameter int SETTLE_CYCLES = 64,
  parameter int DWELL_BITS = 20
) (
  input  logic                  CLK,
  input  logic                  RSTb,
  input  logic                  host_load,
  input  logic [PHASE_BITS-1:0] host_word,
  output logic                  host_ack,
  input  logic                  btn_up,
  input  logic                  btn_dn,
  input  logic [1:0]            step_sel,
  input  logic                  scan_en,
  input  logic [PHASE_BITS-1:0] scan_lo,
  input  logic [PHASE_BITS-1:0] scan_hi,
  input  logic [DWELL_BITS-1:0] dwell,
  input  logic                  carrier_det,
  output logic [PHASE_BITS-1:0] phase_inc,
  output logic                  retune,
  output logic                  mute,
  output logic                  busy,
  output logic [2:0]            state
);
  localparam int PB = PHASE_BITS;
  state_t st, st_nxt;
  logic [PB-1:0] step, inc_nxt, up_clamp, dn_clamp;
  logic [PB:0] up_sum, dn_dif;
  logic apply, ack_nxt, settle_done;
  assign step = PB'(step_val(step_sel));
  assign up_sum = {1'b0, phase_inc} + {1'b0, step};
  assign dn_dif = {1'b0, phase_inc} - {1'b0, step};
  assign up_clamp = up_sum > {1'b0, F_MAX} ? F_MAX : up_sum[PB-1:0];
  assign dn_clamp = (dn_dif[PB] || dn_dif[PB-1:0] < F_MIN) ? F_MIN : dn_dif[PB-1:0];
`ifdef MIXER_TUNE_SCAN_EN
  logic [DWELL_BITS-1:0] dcnt, dcnt_nxt;
  logic [PB-1:0] scan_nxt;
  assign scan_nxt = (up_sum > {1'b0, scan_hi} || phase_inc < scan_lo) ? scan_lo : up_sum[PB-1:0];
  always_ff @(posedge CLK or negedge RSTb)
    if (!RSTb) dcnt <= '0;
    else dcnt <= dcnt_nxt;
`else
  logic unused_scan;
  assign unused_scan = ^{scan_en, scan_lo, scan_hi, dwell, carrier_det};
`endif
  always_comb begin
    st_nxt = st;
    inc_nxt = phase_inc;
    apply = 1'b0;
    ack_nxt = 1'b0;
`ifdef MIXER_TUNE_SCAN_EN
    dcnt_nxt = dcnt;
`endif
    if (host_load) begin
      apply = 1'b1;
      ack_nxt = 1'b1;
      inc_nxt = host_word;
    end else if (btn_up ^ btn_dn) begin
      apply = 1'b1;
      inc_nxt = btn_up ? up_clamp : dn_clamp;
    end else begin
      case (st)
`ifdef MIXER_TUNE_SCAN_EN
        S_IDLE: begin
          apply = scan_en;
          inc_nxt = scan_en ? scan_lo : phase_inc;
        end
        S_SETTLE: begin
          st_nxt = settle_done ? (scan_en ? S_DWELL : S_IDLE) : st;
          dcnt_nxt = dwell;
        end
        S_DWELL: begin
          st_nxt = !scan_en ? S_IDLE : carrier_det ? S_HOLD : dcnt == '0 ? S_STEP : st;
          dcnt_nxt = dcnt - DWELL_BITS'(dcnt != '0);
        end
        S_STEP: begin
          apply = scan_en;
          inc_nxt = scan_en ? scan_nxt : phase_inc;
          st_nxt = S_IDLE;
        end
        S_HOLD: st_nxt = scan_en ? st : S_IDLE;
`else
        S_SETTLE: st_nxt = settle_done ? S_IDLE : st;
`endif
        default: st_nxt = S_IDLE;
      endcase
    end
    if (apply) st_nxt = S_SETTLE;
  end
  always_ff @(posedge CLK or negedge RSTb)
    if (!RSTb) begin
      st <= S_IDLE;
      phase_inc <= F_MIN;
      retune <= 1'b0;
      host_ack <= 1'b0;
    end else begin
      st <= st_nxt;
      phase_inc <= inc_nxt;
      retune <= apply;
      host_ack <= ack_nxt;
    end
  mixer_tune_settle #(.CYCLES(SETTLE_CYCLES)) u_settle (
    .CLK(CLK),
    .RSTb(RSTb),
    .load(apply),
    .mute(mute),
    .done(settle_done)
  );
  assign busy = !(st == S_IDLE || st == S_HOLD);
  assign state = st;
endmodule

// File: tb/tb_mixer_tune_ctrl.sv
// tb_mixer_tune_ctrl: randomized and directed checks of mixer_tune_ctrl against an arithmetic model
module tb_mixer_tune_ctrl;
  localparam longint FMIN = 13422;
  localparam longint FMAX = 40265318;
  localparam int SETTLE = 64;
  logic CLK = 1'b0;
  logic RSTb;
  logic host_load, btn_up, btn_dn, scan_en, carrier_det;
  logic [25:0] host_word, scan_lo, scan_hi;
  logic [1:0] step_sel;
  logic [19:0] dwell;
  logic host_ack, retune, mute, busy;
  logic [25:0] phase_inc;
  logic [2:0] state;
  int checks = 0;
  int failures = 0;
  longint steps [4] = '{1342, 6711, 13422, 134218};

  mixer_tune_ctrl dut (
    .CLK(CLK), .RSTb(RSTb),
    .host_load(host_load), .host_word(host_word), .host_ack(host_ack),
    .btn_up(btn_up), .btn_dn(btn_dn), .step_sel(step_sel),
    .scan_en(scan_en), .scan_lo(scan_lo), .scan_hi(scan_hi), .dwell(dwell),
    .carrier_det(carrier_det),
    .phase_inc(phase_inc), .retune(retune), .mute(mute), .busy(busy), .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic req(input logic hl, input logic [25:0] hw, input logic bu, input logic bd, input logic [1:0] ss);
    host_load = hl; host_word = hw; btn_up = bu; btn_dn = bd; step_sel = ss;
    tick();
    host_load = 1'b0; btn_up = 1'b0; btn_dn = 1'b0;
  endtask

  task automatic measure_mute(output int n);
    n = 0;
    while (mute === 1'b1 && n < 300) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_idle;
    int n = 0;
    while (!(state === 3'd0 && mute === 1'b0) && n < 400) begin
      n++;
      tick();
    end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL wait_idle: state=%0d mute=%b still not idle after %0d cycles", state, mute, n);
    end
  endtask

  task automatic test_reset;
    RSTb = 1'b0;
    host_load = 0; btn_up = 0; btn_dn = 0; scan_en = 0; carrier_det = 0;
    host_word = 0; scan_lo = 0; scan_hi = 0; step_sel = 0; dwell = 0;
    #12;
    checks++;
    if (phase_inc !== 26'(FMIN) || retune !== 1'b0 || mute !== 1'b0 || busy !== 1'b0 || state !== 3'd0 || host_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset: phase_inc=%0d retune=%b mute=%b busy=%b state=%0d ack=%b, want %0d 0 0 0 0 0", phase_inc, retune, mute, busy, state, host_ack, FMIN);
    end
    @(negedge CLK);
    RSTb = 1'b1;
    tick(); tick();
    checks++;
    if (phase_inc !== 26'(FMIN) || retune !== 1'b0 || state !== 3'd0) begin
      failures++;
      $display("FAIL reset_release: phase_inc=%0d retune=%b state=%0d, want %0d 0 0", phase_inc, retune, state, FMIN);
    end
  endtask

  task automatic test_host;
    int n;
    req(1'b1, 26'd1000000, 1'b0, 1'b0, 2'd0);
    checks++;
    if (phase_inc !== 26'd1000000 || retune !== 1'b1 || host_ack !== 1'b1 || state !== 3'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL host_apply: phase_inc=%0d retune=%b ack=%b state=%0d busy=%b, want 1000000 1 1 1 1", phase_inc, retune, host_ack, state, busy);
    end
    tick();
    checks++;
    if (retune !== 1'b0 || host_ack !== 1'b0) begin
      failures++;
      $display("FAIL host_pulse_width: retune=%b ack=%b, want 0 0", retune, host_ack);
    end
    measure_mute(n);
    checks++;
    if (n + 1 !== SETTLE) begin
      failures++;
      $display("FAIL host_mute_len: got %0d muted cycles, want %0d", n + 1, SETTLE);
    end
    checks++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL host_settle_end: state=%0d busy=%b, want 0 0", state, busy);
    end
  endtask

  task automatic test_buttons;
    req(1'b1, 26'(FMAX - 100), 1'b0, 1'b0, 2'd0);
    wait_idle();
    req(1'b0, 26'd0, 1'b1, 1'b0, 2'd3);
    checks++;
    if (phase_inc !== 26'(FMAX) || retune !== 1'b1 || host_ack !== 1'b0) begin
      failures++;
      $display("FAIL btn_up_clamp: phase_inc=%0d retune=%b ack=%b, want %0d 1 0", phase_inc, retune, host_ack, FMAX);
    end
    req(1'b0, 26'd0, 1'b1, 1'b0, 2'd1);
    checks++;
    if (phase_inc !== 26'(FMAX) || retune !== 1'b1 || state !== 3'd1) begin
      failures++;
      $display("FAIL btn_at_limit: phase_inc=%0d retune=%b state=%0d, want %0d 1 1", phase_inc, retune, state, FMAX);
    end
    wait_idle();
    req(1'b0, 26'd0, 1'b1, 1'b1, 2'd2);
    checks++;
    if (phase_inc !== 26'(FMAX) || retune !== 1'b0 || mute !== 1'b0) begin
      failures++;
      $display("FAIL btn_both: phase_inc=%0d retune=%b mute=%b, want %0d 0 0", phase_inc, retune, mute, FMAX);
    end
    req(1'b1, 26'(FMIN + 5), 1'b0, 1'b0, 2'd0);
    req(1'b0, 26'd0, 1'b0, 1'b1, 2'd0);
    checks++;
    if (phase_inc !== 26'(FMIN) || retune !== 1'b1) begin
      failures++;
      $display("FAIL btn_dn_clamp: phase_inc=%0d retune=%b, want %0d 1", phase_inc, retune, FMIN);
    end
    wait_idle();
  endtask

  task automatic test_priority;
    int n;
    req(1'b1, 26'd2222222, 1'b0, 1'b1, 2'd3);
    checks++;
    if (phase_inc !== 26'd2222222 || host_ack !== 1'b1 || retune !== 1'b1) begin
      failures++;
      $display("FAIL host_over_btn: phase_inc=%0d ack=%b retune=%b, want 2222222 1 1", phase_inc, host_ack, retune);
    end
    repeat (9) tick();
    req(1'b1, 26'd3333333, 1'b0, 1'b0, 2'd0);
    checks++;
    if (phase_inc !== 26'd3333333 || retune !== 1'b1 || mute !== 1'b1) begin
      failures++;
      $display("FAIL reload_in_settle: phase_inc=%0d retune=%b mute=%b, want 3333333 1 1", phase_inc, retune, mute);
    end
    measure_mute(n);
    checks++;
    if (n !== SETTLE) begin
      failures++;
      $display("FAIL reload_mute_len: got %0d muted cycles after second load, want %0d", n, SETTLE);
    end
    wait_idle();
  endtask

  task automatic test_random;
    longint m;
    logic [25:0] hw;
    logic [1:0] ss;
    int kind;
    logic exp_ret;
    hw = 26'($urandom);
    req(1'b1, hw, 1'b0, 1'b0, 2'd0);
    m = longint'(hw);
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      hw = 26'($urandom);
      ss = 2'($urandom);
      exp_ret = (kind != 3);
      if (kind == 0) begin
        req(1'b1, hw, 1'b0, 1'b0, ss);
        m = longint'(hw);
      end else if (kind == 1) begin
        req(1'b0, hw, 1'b1, 1'b0, ss);
        m = (m + steps[ss] > FMAX) ? FMAX : m + steps[ss];
      end else if (kind == 2) begin
        req(1'b0, hw, 1'b0, 1'b1, ss);
        m = (m - steps[ss] < FMIN) ? FMIN : m - steps[ss];
      end else begin
        req(1'b0, hw, 1'b1, 1'b1, ss);
      end
      checks++;
      if (phase_inc !== 26'(m) || retune !== exp_ret || host_ack !== (kind == 0)) begin
        failures++;
        $display("FAIL random[%0d] kind=%0d: phase_inc=%0d retune=%b ack=%b, want %0d %b %b", i, kind, phase_inc, retune, host_ack, m, exp_ret, kind == 0);
      end
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle();
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    req(1'b1, 26'd5555555, 1'b0, 1'b0, 2'd0);
    repeat (10) tick();
    RSTb = 1'b0;
    #1;
    checks++;
    if (phase_inc !== 26'(FMIN) || mute !== 1'b0 || state !== 3'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: phase_inc=%0d mute=%b state=%0d busy=%b, want %0d 0 0 0", phase_inc, mute, state, busy, FMIN);
    end
    @(negedge CLK);
    RSTb = 1'b1;
    repeat (5) begin
      tick();
      if (retune !== 1'b0 || mute !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_mid_release: retune or mute seen after release, want none");
    end
  endtask

`ifdef MIXER_TUNE_SCAN_EN
  task automatic test_scan;
    longint exp_seq [4];
    longint p;
    int n, gap;
    exp_seq[0] = 100000;
    p = 100000;
    for (int k = 1; k < 4; k++) begin
      p = (p + steps[0] > 103000 || p < 100000) ? 100000 : p + steps[0];
      exp_seq[k] = p;
    end
    scan_lo = 26'd100000; scan_hi = 26'd103000; dwell = 20'd5; step_sel = 2'd0;
    scan_en = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (retune !== 1'b1 || phase_inc !== 26'(exp_seq[k])) begin
        failures++;
        $display("FAIL scan_point[%0d]: retune=%b phase_inc=%0d, want 1 %0d", k, retune, phase_inc, exp_seq[k]);
      end
      if (k == 3) break;
      measure_mute(n);
      gap = 0;
      while (retune !== 1'b1 && gap < 300) begin
        gap++;
        tick();
      end
      checks++;
      if (n !== SETTLE || gap !== 7) begin
        failures++;
        $display("FAIL scan_timing[%0d]: muted=%0d dwell+step=%0d, want %0d 7", k, n, gap, SETTLE);
      end
    end
    wait_idle_scan_point(26'd101342);
  endtask

  task automatic wait_idle_scan_point(input logic [25:0] target);
    int n = 0;
    bit moved = 0;
    while (!(retune === 1'b1 && phase_inc === target) && n < 400) begin
      n++;
      tick();
    end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL scan_reach: phase_inc=%0d never retuned to %0d", phase_inc, target);
    end
    repeat (66) tick();
    carrier_det = 1'b1;
    tick();
    checks++;
    if (state !== 3'd4 || busy !== 1'b0 || phase_inc !== target) begin
      failures++;
      $display("FAIL scan_hold: state=%0d busy=%b phase_inc=%0d, want 4 0 %0d", state, busy, phase_inc, target);
    end
    carrier_det = 1'b0;
    repeat (150) begin
      tick();
      if (retune !== 1'b0 || phase_inc !== target || state !== 3'd4) moved = 1;
    end
    checks++;
    if (moved) begin
      failures++;
      $display("FAIL hold_frozen: state=%0d phase_inc=%0d, want 4 %0d with no retune", state, phase_inc, target);
    end
    scan_en = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || retune !== 1'b0) begin
      failures++;
      $display("FAIL hold_exit: state=%0d retune=%b, want 0 0", state, retune);
    end
  endtask
`else
  task automatic test_scan;
    bit seen = 0;
    scan_lo = 26'd100000; scan_hi = 26'd103000; dwell = 20'd5; step_sel = 2'd0;
    scan_en = 1'b1;
    carrier_det = 1'b1;
    repeat (100) begin
      tick();
      if (retune !== 1'b0 || state !== 3'd0 || phase_inc !== 26'(FMIN)) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL scan_ignored: state=%0d phase_inc=%0d, want 0 %0d with no retune", state, phase_inc, FMIN);
    end
    scan_en = 1'b0;
    carrier_det = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_host();
    test_buttons();
    test_priority();
    test_random();
    test_reset_mid();
    test_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
